// File: rtl/wisc_trace_pkg.sv
// Shared types for the WISC retire monitor: record layout, FSM states, default sizes.
// The record struct is laid out with the default widths below.
package wisc_trace_pkg;

  localparam int ARCH_WIDTH_DEF = 16;
  localparam int REG_WIDTH_DEF  = 4;
  localparam int FIFO_DEPTH_DEF = 4;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_DRAIN   = 2'd1,
    ST_HALTED  = 2'd2
  } mon_state_e;

  typedef struct packed {
    logic [ARCH_WIDTH_DEF-1:0] pc;
    logic [ARCH_WIDTH_DEF-1:0] inst;
    logic                      regwrite;
    logic [REG_WIDTH_DEF-1:0]  wreg;
    logic [ARCH_WIDTH_DEF-1:0] wdata;
    logic                      memread;
    logic                      memwrite;
    logic [ARCH_WIDTH_DEF-1:0] memaddr;
    logic [ARCH_WIDTH_DEF-1:0] memdin;
    logic [ARCH_WIDTH_DEF-1:0] memdout;
    logic                      halt;
  } ret_rec_t;

  // Saturating increment used by the performance counters.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
    return (en && (v != 32'hFFFF_FFFF)) ? v + 32'd1 : v;
  endfunction

endpackage

// File: rtl/wisc_retire_fifo.sv
// Generic synchronous FIFO of records with full/empty/count status.
// DEPTH must be a power of two so the pointers wrap naturally.
module wisc_retire_fifo #(
  parameter type rec_t = logic [7:0],
  parameter int  DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  rec_t                     wr_rec,
  output rec_t                     rd_rec,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int             PW       = $clog2(DEPTH);
  localparam logic [PW:0]    FULL_CNT = DEPTH[PW:0];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic          push_ok, pop_ok;
  rec_t          mem_q [DEPTH];

  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rd_rec  = mem_q[rd_ptr_q];

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push_ok && !pop_ok)      count_d = count_q + 1'b1;
    else if (pop_ok && !push_ok) count_d = count_q - 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; clearing the pointers already discards it.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wr_rec;
  end

endmodule

// File: rtl/wisc_retire_monitor.sv
// Retire-trace monitor: buffers retiring instructions, drains on HLT, flags mem protocol errors.
// Optional performance counters are enabled with `define WISC_RETIRE_PERF_EN.
module wisc_retire_monitor
  import wisc_trace_pkg::*;
#(
  parameter int ARCH_WIDTH = ARCH_WIDTH_DEF,
  parameter int REG_WIDTH  = REG_WIDTH_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ret_valid,
  output logic                  ret_ready,
  input  logic [ARCH_WIDTH-1:0] ret_pc,
  input  logic [ARCH_WIDTH-1:0] ret_inst,
  input  logic                  ret_regwrite,
  input  logic [REG_WIDTH-1:0]  ret_wreg,
  input  logic [ARCH_WIDTH-1:0] ret_wdata,
  input  logic                  ret_memread,
  input  logic                  ret_memwrite,
  input  logic [ARCH_WIDTH-1:0] ret_memaddr,
  input  logic [ARCH_WIDTH-1:0] ret_memdin,
  input  logic [ARCH_WIDTH-1:0] ret_memdout,
  input  logic                  ret_halt,
  output logic                  rec_valid,
  input  logic                  rec_ready,
  output logic [ARCH_WIDTH-1:0] rec_pc,
  output logic [ARCH_WIDTH-1:0] rec_inst,
  output logic                  rec_regwrite,
  output logic [REG_WIDTH-1:0]  rec_wreg,
  output logic [ARCH_WIDTH-1:0] rec_wdata,
  output logic                  rec_memread,
  output logic                  rec_memwrite,
  output logic [ARCH_WIDTH-1:0] rec_memaddr,
  output logic [ARCH_WIDTH-1:0] rec_memdin,
  output logic [ARCH_WIDTH-1:0] rec_memdout,
  output logic                  rec_halt,
  output logic                  halted,
  output logic                  err,
  output logic [31:0]           cycle_cnt,
  output logic [31:0]           inst_cnt,
  output logic [31:0]           bp_cnt
);

  localparam int          CW      = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  mon_state_e    state_q, state_d;
  logic          err_q, err_d;
  ret_rec_t      push_rec, head_rec;
  logic          fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;
  logic          push, pop;

  // Ready depends only on registered state, never on ret_valid.
  assign ret_ready = (state_q == ST_RUN) && !fifo_full;
  assign push      = ret_valid && ret_ready;
  assign rec_valid = !fifo_empty;
  assign pop       = rec_valid && rec_ready;
  assign halted    = (state_q == ST_HALTED);
  assign err       = err_q;

  assign push_rec = '{pc: ret_pc, inst: ret_inst, regwrite: ret_regwrite, wreg: ret_wreg,
                      wdata: ret_wdata, memread: ret_memread, memwrite: ret_memwrite,
                      memaddr: ret_memaddr, memdin: ret_memdin, memdout: ret_memdout,
                      halt: ret_halt};

  wisc_retire_fifo #(
    .rec_t (ret_rec_t),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .push   (push),
    .pop    (pop),
    .wr_rec (push_rec),
    .rd_rec (head_rec),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (fifo_count)
  );

  assign rec_pc       = head_rec.pc;
  assign rec_inst     = head_rec.inst;
  assign rec_regwrite = head_rec.regwrite;
  assign rec_wreg     = head_rec.wreg;
  assign rec_wdata    = head_rec.wdata;
  assign rec_memread  = head_rec.memread;
  assign rec_memwrite = head_rec.memwrite;
  assign rec_memaddr  = head_rec.memaddr;
  assign rec_memdin   = head_rec.memdin;
  assign rec_memdout  = head_rec.memdout;
  assign rec_halt     = head_rec.halt;

  // DRAIN admits no pushes, so the last pop out of a one-entry FIFO empties it.
  always_comb begin
    state_d = state_q;
    err_d   = err_q | (push && ret_memread && ret_memwrite);
    unique case (state_q)
      ST_RUN:    if (push && ret_halt) state_d = ST_DRAIN;
      ST_DRAIN:  if (pop && (fifo_count == CNT_ONE)) state_d = ST_HALTED;
      ST_HALTED: state_d = ST_HALTED;
      default:   state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
    end
  end

`ifdef WISC_RETIRE_PERF_EN
  logic [31:0] cycle_cnt_q, cycle_cnt_d;
  logic [31:0] inst_cnt_q, inst_cnt_d;
  logic [31:0] bp_cnt_q, bp_cnt_d;

  always_comb begin
    cycle_cnt_d = sat_inc(cycle_cnt_q, state_q != ST_HALTED);
    inst_cnt_d  = sat_inc(inst_cnt_q, push);
    bp_cnt_d    = sat_inc(bp_cnt_q, (state_q == ST_RUN) && ret_valid && !ret_ready);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt_q <= '0;
      inst_cnt_q  <= '0;
      bp_cnt_q    <= '0;
    end else begin
      cycle_cnt_q <= cycle_cnt_d;
      inst_cnt_q  <= inst_cnt_d;
      bp_cnt_q    <= bp_cnt_d;
    end
  end

  assign cycle_cnt = cycle_cnt_q;
  assign inst_cnt  = inst_cnt_q;
  assign bp_cnt    = bp_cnt_q;
`else
  assign cycle_cnt = '0;
  assign inst_cnt  = '0;
  assign bp_cnt    = '0;
`endif

endmodule

// File: tb/tb_wisc_retire_monitor.sv
// Self-checking bench for wisc_retire_monitor: directed table, corner sequences, random traffic
// compared against a queue-based reference model.
module tb_wisc_retire_monitor;
  import wisc_trace_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ret_valid, ret_ready, rec_valid, rec_ready;
  logic        halted, err;
  logic [31:0] cycle_cnt, inst_cnt, bp_cnt;
  logic [15:0] rec_pc, rec_inst, rec_wdata, rec_memaddr, rec_memdin, rec_memdout;
  logic [3:0]  rec_wreg;
  logic        rec_regwrite, rec_memread, rec_memwrite, rec_halt;
  ret_rec_t    cur, dut_rec;

  always #5 clk = ~clk;

  wisc_retire_monitor dut (
    .clk(clk), .rst_n(rst_n),
    .ret_valid(ret_valid), .ret_ready(ret_ready),
    .ret_pc(cur.pc), .ret_inst(cur.inst),
    .ret_regwrite(cur.regwrite), .ret_wreg(cur.wreg), .ret_wdata(cur.wdata),
    .ret_memread(cur.memread), .ret_memwrite(cur.memwrite),
    .ret_memaddr(cur.memaddr), .ret_memdin(cur.memdin), .ret_memdout(cur.memdout),
    .ret_halt(cur.halt),
    .rec_valid(rec_valid), .rec_ready(rec_ready),
    .rec_pc(rec_pc), .rec_inst(rec_inst),
    .rec_regwrite(rec_regwrite), .rec_wreg(rec_wreg), .rec_wdata(rec_wdata),
    .rec_memread(rec_memread), .rec_memwrite(rec_memwrite),
    .rec_memaddr(rec_memaddr), .rec_memdin(rec_memdin), .rec_memdout(rec_memdout),
    .rec_halt(rec_halt),
    .halted(halted), .err(err),
    .cycle_cnt(cycle_cnt), .inst_cnt(inst_cnt), .bp_cnt(bp_cnt)
  );

  assign dut_rec = '{pc: rec_pc, inst: rec_inst, regwrite: rec_regwrite, wreg: rec_wreg,
                     wdata: rec_wdata, memread: rec_memread, memwrite: rec_memwrite,
                     memaddr: rec_memaddr, memdin: rec_memdin, memdout: rec_memdout,
                     halt: rec_halt};

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: an ordered list of buffered records plus a mode flag.
  typedef enum {M_RUN, M_DRAIN, M_HALT} mode_e;
  ret_rec_t    mq[$];
  mode_e       mode;
  bit          m_err;
  int unsigned m_cyc, m_inst, m_bp;
  int          popped;

  function automatic int unsigned sat_up(input int unsigned x);
    return (x == 32'hFFFF_FFFF) ? x : x + 1;
  endfunction

  function automatic logic [31:0] perf(input int unsigned x);
`ifdef WISC_RETIRE_PERF_EN
    return x;
`else
    return (x == 0) ? 32'd0 : 32'd0;
`endif
  endfunction

  function automatic ret_rec_t mk_rec(input logic [15:0] pc);
    ret_rec_t r;
    r          = '0;
    r.pc       = pc;
    r.inst     = pc ^ 16'hA5A5;
    r.regwrite = 1'b1;
    r.wreg     = pc[4:1];
    r.wdata    = pc + 16'd7;
    return r;
  endfunction

  function automatic ret_rec_t rand_rec();
    ret_rec_t r;
    r.pc       = 16'($urandom);
    r.inst     = 16'($urandom);
    r.regwrite = 1'($urandom);
    r.wreg     = 4'($urandom);
    r.wdata    = 16'($urandom);
    r.memread  = ($urandom_range(0, 3) == 0);
    r.memwrite = ($urandom_range(0, 3) == 0);
    r.memaddr  = 16'($urandom);
    r.memdin   = 16'($urandom);
    r.memdout  = 16'($urandom);
    r.halt     = ($urandom_range(0, 63) == 0);
    return r;
  endfunction

  // Called just after a rising edge; inputs settle before the mid-cycle comparison.
  task automatic drive(input logic v, input ret_rec_t r, input logic rr);
    ret_valid = v;
    cur       = r;
    rec_ready = rr;
    #3;
  endtask

  // Compare DUT against the model, then advance both through one rising edge.
  task automatic advance(output bit pushed);
    bit exp_ready, exp_rv, do_pop;
    exp_ready = (mode == M_RUN) && (mq.size() < DEPTH);
    exp_rv    = (mq.size() != 0);
    check("ret_ready", ret_ready, exp_ready);
    check("rec_valid", rec_valid, exp_rv);
    if (exp_rv) check("rec_head", dut_rec, mq[0]);
    check("halted", halted, mode == M_HALT);
    check("err", err, m_err);
    check("cycle_cnt", cycle_cnt, perf(m_cyc));
    check("inst_cnt", inst_cnt, perf(m_inst));
    check("bp_cnt", bp_cnt, perf(m_bp));
    pushed = ret_valid && exp_ready;
    do_pop = exp_rv && rec_ready;
    if (mode != M_HALT) m_cyc = sat_up(m_cyc);
    if (pushed) m_inst = sat_up(m_inst);
    if (mode == M_RUN && ret_valid && !exp_ready) m_bp = sat_up(m_bp);
    if (do_pop) begin
      void'(mq.pop_front());
      popped++;
    end
    if (pushed) mq.push_back(cur);
    if (pushed && cur.memread && cur.memwrite) m_err = 1'b1;
    if (mode == M_RUN && pushed && cur.halt) mode = M_DRAIN;
    else if (mode == M_DRAIN && mq.size() == 0) mode = M_HALT;
    @(posedge clk);
    #1;
  endtask

  task automatic step(input logic v, input ret_rec_t r, input logic rr, output bit pushed);
    drive(v, r, rr);
    advance(pushed);
  endtask

  // Pulse reset entirely between two edges and check the asynchronous clear.
  task automatic do_reset();
    ret_valid = 1'b0;
    rec_ready = 1'b0;
    cur       = '0;
    rst_n     = 1'b0;
    #1;
    check("rst_rec_valid", rec_valid, 1'b0);
    check("rst_halted", halted, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_ret_ready", ret_ready, 1'b1);
    check("rst_cycle_cnt", cycle_cnt, 32'd0);
    check("rst_inst_cnt", inst_cnt, 32'd0);
    check("rst_bp_cnt", bp_cnt, 32'd0);
    mq.delete();
    mode   = M_RUN;
    m_err  = 1'b0;
    m_cyc  = 0;
    m_inst = 0;
    m_bp   = 0;
    popped = 0;
    #1 rst_n = 1'b1;
  endtask

  typedef struct {
    logic        v;
    logic [15:0] pc;
    logic        rr;
    logic        exp_ready;
    logic        exp_rv;
    logic [15:0] exp_pc;
  } vec_t;

  vec_t tbl[5];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    bit p;
    int n;
    tbl[0] = '{1'b1, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0000};
    tbl[1] = '{1'b1, 16'h0002, 1'b1, 1'b1, 1'b1, 16'h0000};
    tbl[2] = '{1'b1, 16'h0004, 1'b1, 1'b1, 1'b1, 16'h0002};
    tbl[3] = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 16'h0004};
    tbl[4] = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0000};

    rst_n     = 1'b0;
    ret_valid = 1'b0;
    rec_ready = 1'b0;
    cur       = '0;
    @(posedge clk);
    #1;
    do_reset();

    // Three records flow through with one cycle of latency each.
    foreach (tbl[i]) begin
      drive(tbl[i].v, mk_rec(tbl[i].pc), tbl[i].rr);
      check($sformatf("tbl%0d_ret_ready", i), ret_ready, tbl[i].exp_ready);
      check($sformatf("tbl%0d_rec_valid", i), rec_valid, tbl[i].exp_rv);
      if (tbl[i].exp_rv) check($sformatf("tbl%0d_rec_pc", i), rec_pc, tbl[i].exp_pc);
      advance(p);
    end
    check("tbl_inst_cnt", inst_cnt, perf(3));

    // Backpressure: fill a four-entry FIFO, stall a fifth push, then drain all five.
    do_reset();
    n = 0;
    for (int c = 0; c < 7; c++) begin
      step(1'b1, mk_rec(16'h0100 + 16'(2 * n)), 1'b0, p);
      if (p) n++;
    end
    check("bp_pushed_before_stall", n, 4);
    check("bp_cnt_stall", bp_cnt, perf(3));
    for (int c = 0; c < 20 && (n < 5 || mq.size() != 0); c++) begin
      step(n < 5, mk_rec(16'h0100 + 16'(2 * n)), 1'b1, p);
      if (p) n++;
    end
    check("bp_all_out", popped, 5);

    // Full-rate push and pop: occupancy holds at one while pointers wrap.
    do_reset();
    n = 0;
    for (int c = 0; c < 11; c++) begin
      step(n < 10, mk_rec(16'h0200 + 16'(2 * n)), 1'b1, p);
      if (p) n++;
      if (c > 0 && c < 10) check("stream_occupancy", mq.size(), 1);
    end
    check("stream_popped", popped, 10);

    // HLT drain: two records then the halt, sink stalled, then three pops.
    do_reset();
    step(1'b1, mk_rec(16'h0300), 1'b0, p);
    step(1'b1, mk_rec(16'h0302), 1'b0, p);
    cur      = mk_rec(16'h0304);
    cur.halt = 1'b1;
    step(1'b1, cur, 1'b0, p);
    step(1'b1, mk_rec(16'h0306), 1'b0, p);
    check("hlt_no_push", p, 1'b0);
    step(1'b0, '0, 1'b0, p);
    step(1'b0, '0, 1'b1, p);
    step(1'b0, '0, 1'b1, p);
    check("hlt_not_yet", halted, 1'b0);
    step(1'b0, '0, 1'b1, p);
    check("hlt_halted", halted, 1'b1);
    for (int c = 0; c < 3; c++) step(1'b1, mk_rec(16'h0400), 1'b1, p);
    check("hlt_cycle_freeze", cycle_cnt, perf(8));

    // Memory read+write conflict raises a sticky error; reset mid-fill clears everything.
    do_reset();
    cur          = mk_rec(16'h0500);
    cur.memread  = 1'b1;
    cur.memwrite = 1'b1;
    cur.memaddr  = 16'h0010;
    step(1'b1, cur, 1'b1, p);
    step(1'b0, '0, 1'b1, p);
    step(1'b0, '0, 1'b1, p);
    check("err_sticky", err, 1'b1);
    step(1'b1, mk_rec(16'h0600), 1'b0, p);
    step(1'b1, mk_rec(16'h0602), 1'b0, p);
    do_reset();
    step(1'b0, '0, 1'b1, p);

    // Random traffic with occasional halts and resets.
    n = 0;
    for (int c = 0; c < 3000; c++) begin
      if ((mode == M_HALT && n > 4) || $urandom_range(0, 399) == 0) begin
        do_reset();
        n = 0;
      end
      if (mode == M_HALT) n++;
      step($urandom_range(0, 9) < 7, rand_rec(), $urandom_range(0, 9) < 6, p);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
